// File: rtl/dma_priority_arbiter.sv
// ============================================================================
// dma_priority_arbiter
//
// Channel arbiter and bus-request sequencer for the 4-channel DMA controller.
// Unmasked DREQ lines are resolved by fixed or rotating priority. The block
// then runs the HRQ/HLDA hold handshake with the CPU and drives a one-hot DACK
// for the winning channel until timing control reports the end of service.
// This block owns the priority order used by the rest of the controller.
//
// Optional feature macro: DMA_HLDA_TIMEOUT_EN
//   defined   : a request that waits HLDA_TIMEOUT cycles without HLDA is
//               abandoned and o_hldaTimeout pulses for one cycle.
//   undefined : REQUEST waits for HLDA indefinitely; o_hldaTimeout is tied 0.
//
// Ports:
//   i_clk               system clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_dreq              channel requests, active-high
//   i_maskReg           1 = channel masked
//   i_priorityType      0 = fixed priority, 1 = rotating priority
//   i_controllerDisable 1 = no new arbitration starts
//   i_hlda              hold acknowledge from CPU
//   i_transferDone      1-cycle pulse at the end of a service
//   i_eop_n             active-low end of process
//   o_hrq               hold request to CPU
//   o_dack              one-hot channel acknowledge
//   o_activeChannel     index of the latched winner
//   o_grantValid        high while DACK is non-zero
//   o_priorityOrder     2-bit fields, [1:0] highest priority, top field lowest
//   o_hldaTimeout       1-cycle pulse when a request is abandoned
// ============================================================================
module dma_priority_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int HLDA_TIMEOUT = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_CH-1:0]                 i_dreq,
    input  logic [NUM_CH-1:0]                 i_maskReg,
    input  logic                              i_priorityType,
    input  logic                              i_controllerDisable,
    input  logic                              i_hlda,
    input  logic                              i_transferDone,
    input  logic                              i_eop_n,
    output logic                              o_hrq,
    output logic [NUM_CH-1:0]                 o_dack,
    output logic [$clog2(NUM_CH)-1:0]         o_activeChannel,
    output logic                              o_grantValid,
    output logic [NUM_CH*$clog2(NUM_CH)-1:0]  o_priorityOrder,
    output logic                              o_hldaTimeout
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int ORDER_W = NUM_CH * CH_W;

    // Elaboration guard: the timeout compare needs at least a 1-bit counter.
    if (HLDA_TIMEOUT < 2) begin : g_badTimeout
        $error("HLDA_TIMEOUT must be at least 2");
    end

    // Identity order: field i holds channel i, so channel 0 is highest.
    function automatic logic [ORDER_W-1:0] identityOrder();
        logic [ORDER_W-1:0] order;
        order = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            order[i*CH_W +: CH_W] = CH_W'(i);
        end
        return order;
    endfunction

    localparam logic [ORDER_W-1:0] DEFAULT_ORDER = identityOrder();

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_hrq;
    logic [NUM_CH-1:0]   r_dack;
    logic [CH_W-1:0]     r_activeChannel;
    logic                r_grantValid;
    logic [ORDER_W-1:0]  r_priorityOrder;

    logic [NUM_CH-1:0]   w_pending;
    logic [CH_W-1:0]     w_winner;
    logic [NUM_CH-1:0]   w_winnerOneHot;
    logic [ORDER_W-1:0]  w_rotOrder;
    logic                w_serviceEnd;

`ifdef DMA_HLDA_TIMEOUT_EN
    localparam int CNT_W = $clog2(HLDA_TIMEOUT);

    logic [CNT_W-1:0]    r_count;
    logic                r_hldaTimeout;
`endif

    // Winner search: walk the order from the lowest-priority field up to the
    // highest so the highest pending field is the last one to overwrite.
    // When nothing is pending the result is unused because every consumer
    // first checks |w_pending.
    always_comb begin
        w_pending = i_dreq & ~i_maskReg;
        w_winner  = r_priorityOrder[CH_W-1:0];
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pending[r_priorityOrder[i*CH_W +: CH_W]]) begin
                w_winner = r_priorityOrder[i*CH_W +: CH_W];
            end
        end
        w_winnerOneHot = NUM_CH'(1) << w_winner;
    end

    // Rotated order after serving the active channel c: fields become
    // c+1, c+2, ..., c (mod NUM_CH), which puts c at the lowest priority.
    // The CH_W-bit add wraps modulo NUM_CH for free.
    always_comb begin
        w_rotOrder = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_rotOrder[i*CH_W +: CH_W] = r_activeChannel + CH_W'(i + 1);
        end
        w_serviceEnd = i_transferDone || !i_eop_n;
    end

    // Main sequencer with registered outputs. The winner keeps retargeting
    // during REQUEST and is frozen on the HLDA edge; a dropped request set is
    // checked before HLDA so a late HLDA never grants a vanished request.
    // The priority order is updated in the same block: fixed mode reloads it
    // every edge, rotating mode changes it only when a service really ends
    // (transferDone and EOP together still give a single rotation).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_hrq           <= 1'b0;
            r_dack          <= '0;
            r_activeChannel <= '0;
            r_grantValid    <= 1'b0;
            r_priorityOrder <= DEFAULT_ORDER;
`ifdef DMA_HLDA_TIMEOUT_EN
            r_count         <= '0;
            r_hldaTimeout   <= 1'b0;
`endif
        end else begin
`ifdef DMA_HLDA_TIMEOUT_EN
            r_count         <= '0;
            r_hldaTimeout   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!i_controllerDisable && (|w_pending)) begin
                        r_activeChannel <= w_winner;
                        r_hrq           <= 1'b1;
                        r_state         <= ST_REQUEST;
                    end
                end

                ST_REQUEST: begin
                    if (w_pending == '0) begin
                        r_hrq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (i_hlda) begin
                        r_activeChannel <= w_winner;
                        r_dack          <= w_winnerOneHot;
                        r_grantValid    <= 1'b1;
                        r_state         <= ST_GRANT;
`ifdef DMA_HLDA_TIMEOUT_EN
                    end else if (r_count == CNT_W'(HLDA_TIMEOUT - 1)) begin
                        r_hldaTimeout <= 1'b1;
                        r_hrq         <= 1'b0;
                        r_state       <= ST_IDLE;
`endif
                    end else begin
                        r_activeChannel <= w_winner;
`ifdef DMA_HLDA_TIMEOUT_EN
                        r_count         <= r_count + 1'b1;
`endif
                    end
                end

                ST_GRANT: begin
                    if (w_serviceEnd || !i_hlda) begin
                        r_hrq        <= 1'b0;
                        r_dack       <= '0;
                        r_grantValid <= 1'b0;
                        r_state      <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!i_hlda) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_hrq        <= 1'b0;
                    r_dack       <= '0;
                    r_grantValid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase

            if (!i_priorityType) begin
                r_priorityOrder <= DEFAULT_ORDER;
            end else if ((r_state == ST_GRANT) && w_serviceEnd) begin
                r_priorityOrder <= w_rotOrder;
            end
        end
    end

    assign o_hrq           = r_hrq;
    assign o_dack          = r_dack;
    assign o_activeChannel = r_activeChannel;
    assign o_grantValid    = r_grantValid;
    assign o_priorityOrder = r_priorityOrder;

`ifdef DMA_HLDA_TIMEOUT_EN
    assign o_hldaTimeout   = r_hldaTimeout;
`else
    assign o_hldaTimeout   = 1'b0;
`endif

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// ============================================================================
// tb_dma_priority_arbiter
//
// Directed bench for dma_priority_arbiter. Expected DACK values are pushed
// to a queue when HLDA is driven and popped when grantValid shows up.
// Build with DMA_HLDA_TIMEOUT_EN defined to exercise the abandon path.
// ============================================================================
module tb_dma_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dreq;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       controllerDisable;
    logic       hlda;
    logic       transferDone;
    logic       eop_n;
    logic       o_hrq;
    logic [3:0] o_dack;
    logic [1:0] o_activeChannel;
    logic       o_grantValid;
    logic [7:0] o_priorityOrder;
    logic       o_hldaTimeout;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] expDackQ[$];

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    dma_priority_arbiter #(
        .NUM_CH       (4),
        .HLDA_TIMEOUT (16)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_dreq              (dreq),
        .i_maskReg           (maskReg),
        .i_priorityType      (priorityType),
        .i_controllerDisable (controllerDisable),
        .i_hlda              (hlda),
        .i_transferDone      (transferDone),
        .i_eop_n             (eop_n),
        .o_hrq               (o_hrq),
        .o_dack              (o_dack),
        .o_activeChannel     (o_activeChannel),
        .o_grantValid        (o_grantValid),
        .o_priorityOrder     (o_priorityOrder),
        .o_hldaTimeout       (o_hldaTimeout)
    );

    // Advance to just after the next rising edge so outputs are settled.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive every input for one clock, then settle after the edge.
    task automatic applyStimulus(input logic [3:0] d, input logic [3:0] m,
                                 input logic p, input logic dis, input logic h,
                                 input logic td, input logic eop);
        dreq              = d;
        maskReg           = m;
        priorityType      = p;
        controllerDisable = dis;
        hlda              = h;
        transferDone      = td;
        eop_n             = eop;
        cycle();
    endtask

    // Pop the next expected grant once grantValid appears (bounded wait).
    task automatic waitGrant(input string tag, input int budget);
        int         waited;
        logic [3:0] exp;
        waited = 0;
        while (!o_grantValid && waited < budget) begin
            cycle();
            waited++;
        end
        checkOutput({tag, "_latency"}, 32'(waited), 32'd0);
        if (expDackQ.size() > 0) exp = expDackQ.pop_front();
        else exp = 4'b0000;
        checkOutput({tag, "_dack"}, 32'(o_dack), 32'(exp));
        checkOutput({tag, "_hrq"}, 32'(o_hrq), 32'd1);
    endtask

    initial begin
        int   waited;
        logic sawDack;
        logic hrqDropped;

        rst_n             = 1'b0;
        dreq              = 4'b0000;
        maskReg           = 4'b0000;
        priorityType      = 1'b0;
        controllerDisable = 1'b0;
        hlda              = 1'b0;
        transferDone      = 1'b0;
        eop_n             = 1'b1;

        // Reset state
        repeat (2) cycle();
        checkOutput("rst_hrq",     32'(o_hrq),           32'd0);
        checkOutput("rst_dack",    32'(o_dack),          32'd0);
        checkOutput("rst_gv",      32'(o_grantValid),    32'd0);
        checkOutput("rst_ac",      32'(o_activeChannel), 32'd0);
        checkOutput("rst_order",   32'(o_priorityOrder), 32'hE4);
        checkOutput("rst_timeout", 32'(o_hldaTimeout),   32'd0);
        rst_n = 1'b1;
        cycle();

        // Fixed priority: ch1 beats ch2, HLDA three cycles after HRQ
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("fix_hrq", 32'(o_hrq), 32'd1);
        checkOutput("fix_ac",  32'(o_activeChannel), 32'd1);
        checkOutput("fix_noDackYet", 32'(o_dack), 32'd0);
        repeat (2) cycle();
        expDackQ.push_back(4'b0010);
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("fixGrant", 4);
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("fixDone_dack",  32'(o_dack), 32'd0);
        checkOutput("fixDone_hrq",   32'(o_hrq), 32'd0);
        checkOutput("fixDone_gv",    32'(o_grantValid), 32'd0);
        checkOutput("fixDone_order", 32'(o_priorityOrder), 32'hE4);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Rotating priority: serve ch0, then ch1 wins from the rotated order
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rot_ac0", 32'(o_activeChannel), 32'd0);
        expDackQ.push_back(4'b0001);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("rotGrant0", 4);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("rot_order39", 32'(o_priorityOrder), 32'h39);
        checkOutput("rot_dackOff", 32'(o_dack), 32'd0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rot_ac1", 32'(o_activeChannel), 32'd1);
        expDackQ.push_back(4'b0010);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("rotGrant1", 4);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("rot_order4E", 32'(o_priorityOrder), 32'h4E);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Masking and retarget before HLDA (fixed mode reloads the order)
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle();
        checkOutput("mask_hrqLow", 32'(o_hrq), 32'd0);
        checkOutput("mask_orderReload", 32'(o_priorityOrder), 32'hE4);
        applyStimulus(4'b0100, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mask_hrq", 32'(o_hrq), 32'd1);
        checkOutput("mask_ac2", 32'(o_activeChannel), 32'd2);
        applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("retarget_ac0", 32'(o_activeChannel), 32'd0);
        expDackQ.push_back(4'b0001);
        applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("retargetGrant", 4);
        applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // EOP ends a ch2 service in rotating mode; DACK ignores DREQ changes
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expDackQ.push_back(4'b0100);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("eopGrant", 4);
        applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("eop_dackHeld", 32'(o_dack), 32'h4);
        applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("eop_dackOff", 32'(o_dack), 32'd0);
        checkOutput("eop_hrqOff",  32'(o_hrq), 32'd0);
        checkOutput("eop_order93", 32'(o_priorityOrder), 32'h93);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // HLDA revoked mid-grant: release without rotation
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expDackQ.push_back(4'b0100);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("revokeGrant", 4);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("revoke_dack",  32'(o_dack), 32'd0);
        checkOutput("revoke_gv",    32'(o_grantValid), 32'd0);
        checkOutput("revoke_order", 32'(o_priorityOrder), 32'h93);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // HLDA arrives in the same cycle the requests vanish: no grant
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("race_hrq",  32'(o_hrq), 32'd0);
        checkOutput("race_gv",   32'(o_grantValid), 32'd0);
        checkOutput("race_dack", 32'(o_dack), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Disable blocks only new starts; TD+EOP together rotate once
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("dis_hrqLow", 32'(o_hrq), 32'd0);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("dis_hrqHigh", 32'(o_hrq), 32'd1);
        expDackQ.push_back(4'b0010);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        waitGrant("disGrant", 4);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("tdEop_order4E", 32'(o_priorityOrder), 32'h4E);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // HLDA never arrives for ch3
        applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("to_hrqRise", 32'(o_hrq), 32'd1);
        sawDack = 1'b0;
`ifdef DMA_HLDA_TIMEOUT_EN
        waited = 0;
        while (!o_hldaTimeout && waited < 40) begin
            cycle();
            waited++;
            if (o_dack != 4'b0000) sawDack = 1'b1;
        end
        checkOutput("to_pulseDelay", 32'(waited), 32'd16);
        checkOutput("to_pulse", 32'(o_hldaTimeout), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("to_pulseEnd", 32'(o_hldaTimeout), 32'd0);
        checkOutput("to_hrqLow",   32'(o_hrq), 32'd0);
`else
        hrqDropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_dack != 4'b0000) sawDack = 1'b1;
            if (!o_hrq || o_hldaTimeout) hrqDropped = 1'b1;
        end
        checkOutput("noTo_hrqHeld", 32'(hrqDropped), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("noTo_hrqLow", 32'(o_hrq), 32'd0);
`endif
        checkOutput("to_noDack",  32'(sawDack), 32'd0);
        checkOutput("to_orderKept", 32'(o_priorityOrder), 32'h4E);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a grant
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expDackQ.push_back(4'b0001);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitGrant("preResetGrant", 4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRst_hrq",   32'(o_hrq), 32'd0);
        checkOutput("midRst_dack",  32'(o_dack), 32'd0);
        checkOutput("midRst_gv",    32'(o_grantValid), 32'd0);
        checkOutput("midRst_order", 32'(o_priorityOrder), 32'hE4);
        dreq = 4'b0000;
        hlda = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        checkOutput("scoreboard_empty", 32'(expDackQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
